otter_clock_ctrl: RTL and testbench

- Run-control controller for the OTTER divided CPU clock.
- Counts system-clock cycles to produce a divided clock (CLK_OUT) and a matching one-cycle enable pulse (CLK_EN).
- Adds halt, free-run, single-step and glitch-free runtime update of the divide ratio.
- Sits between the board clock and the CPU/debug logic; the debug interface drives RUN/STEP/DIV_WR.

---
 rtl/otter_clock_ctrl.sv | 172 +++++++++++++++++
 tb/tb_otter_clock_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/otter_clock_ctrl.sv
// Run-control for the OTTER divided CPU clock: divided clock plus enable pulse,
// with halt/free-run/single-step and boundary-aligned updates of the divide ratio.
module otter_clock_ctrl #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 200000,
  parameter int unsigned MIN_DIV     = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RUN,
  input  logic                 STEP,
  input  logic [CNT_WIDTH-1:0] DIV_VAL,
  input  logic                 DIV_WR,
  output logic                 DIV_ACK,
  output logic                 CLK_OUT,
  output logic                 CLK_EN,
  output logic                 STEP_DONE,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEFAULT_DIV_C = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] MIN_DIV_C     = CNT_WIDTH'(MIN_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE_C         = CNT_WIDTH'(1);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_div_active;
  logic [CNT_WIDTH-1:0]   r_div_pend;
  logic                   r_pend;
  logic                   r_clk_out;
  logic                   r_clk_en;
  logic                   r_apply_d;
  logic                   r_div_ack;
  logic                   r_step_done;

  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_clk_nxt;
  logic                   w_en_nxt;
  logic                   w_done_nxt;
  logic                   w_counting;
  logic                   w_apply;
  logic                   w_tc;
  logic                   w_fall;
  logic [CNT_WIDTH-1:0]   w_div_clamped;

  assign w_tc          = (r_cnt == r_div_active);
  assign w_fall        = w_tc & r_clk_out;
  assign w_div_clamped = (DIV_VAL < MIN_DIV_C) ? MIN_DIV_C : DIV_VAL;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk_out;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_counting  = 1'b0;
    w_apply     = 1'b0;

    case (r_state)
      ST_HALT: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (RUN) begin
          w_state_nxt = ST_RUN;
        end else if (STEP) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!RUN && !r_clk_out) begin
          // Low phase can be abandoned at once; a coincident rise is suppressed.
          w_state_nxt = ST_HALT;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
        end else begin
          w_counting = 1'b1;
          if (!RUN) begin
            w_state_nxt = w_fall ? ST_HALT : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_counting = 1'b1;
        if (RUN) begin
          w_state_nxt = ST_RUN;
        end else if (w_fall) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        w_counting = 1'b1;
        if (w_fall) begin
          w_state_nxt = ST_HALT;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase

    if (w_counting) begin
      if (w_tc) begin
        w_cnt_nxt = '0;
        w_clk_nxt = ~r_clk_out;
        w_en_nxt  = ~r_clk_out;
      end else begin
        w_cnt_nxt = r_cnt + ONE_C;
      end
    end

    // New ratios only take effect while idle or right after a falling edge,
    // so no shortened phase is ever produced.
    w_apply = r_pend && ((r_state == ST_HALT) || (w_counting && w_fall));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_HALT;
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_clk_en    <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_clk_out   <= w_clk_nxt;
      r_clk_en    <= w_en_nxt;
      r_step_done <= w_done_nxt;
    end
  end

  // A write in the application cycle overrides the clear and stays pending.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_active <= DEFAULT_DIV_C;
      r_div_pend   <= DEFAULT_DIV_C;
      r_pend       <= 1'b0;
      r_apply_d    <= 1'b0;
      r_div_ack    <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div_active <= r_div_pend;
      end
      if (DIV_WR) begin
        r_div_pend <= w_div_clamped;
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
      r_apply_d <= w_apply;
      r_div_ack <= r_apply_d;
    end
  end

  assign DIV_ACK   = r_div_ack;
  assign CLK_OUT   = r_clk_out;
  assign CLK_EN    = r_clk_en;
  assign STEP_DONE = r_step_done;
  assign STATE     = r_state;

endmodule

// File: tb/tb_otter_clock_ctrl.sv
// Bench for otter_clock_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and compared against the DUT after each clock edge.
module tb_otter_clock_ctrl;

  localparam int W   = 8;
  localparam int DEF = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic         div_wr = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_ack;
  logic         clk_out;
  logic         clk_en;
  logic         step_done;
  logic [1:0]   state;
  logic [5:0]   obs;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  otter_clock_ctrl #(
    .CNT_WIDTH  (W),
    .DEFAULT_DIV(DEF),
    .MIN_DIV    (1)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .RUN      (run),
    .STEP     (step),
    .DIV_VAL  (div_val),
    .DIV_WR   (div_wr),
    .DIV_ACK  (div_ack),
    .CLK_OUT  (clk_out),
    .CLK_EN   (clk_en),
    .STEP_DONE(step_done),
    .STATE    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign obs = {state, clk_out, clk_en, div_ack, step_done};

  // Vector layout: {STATE[1:0], CLK_OUT, CLK_EN, DIV_ACK, STEP_DONE}
  function automatic logic [5:0] mk(input logic [1:0] s, input logic c, input logic e,
                                    input logic a, input logic d);
    return {s, c, e, a, d};
  endfunction

  // Free-running waveform t edges after entering a counting state with cnt=0:
  // half-period d+1 cycles, enable in the first high cycle. Returns {clk, en}.
  function automatic logic [1:0] wave(input int t, input int d);
    logic c;
    logic e;
    c = ((t / (d + 1)) % 2) == 1;
    e = (t % (2 * (d + 1))) == (d + 1);
    return {c, e};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk_val(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk_val(tag, obs, e);
    end
  endtask

  // ---------------- drivers ----------------
  // Called on a negedge: drive inputs, queue the expectation, check after the posedge.
  task automatic drive_cycle(input string tag, input logic r, input logic s, input logic wr,
                             input logic [W-1:0] v, input logic [5:0] e);
    run     = r;
    step    = s;
    div_wr  = wr;
    div_val = v;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    sb_compare(tag);
  endtask

  // Asserts reset mid low-phase and checks outputs before any clock edge.
  task automatic async_reset(input string tag);
    run     = 1'b0;
    step    = 1'b0;
    div_wr  = 1'b0;
    div_val = '0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    sb_compare(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wv;
    @(negedge clk);

    // A: reset state, then free-run with default divide
    async_reset("A_rst");
    for (int n = 0; n < 24; n++) begin
      wv = wave(n, DEF);
      drive_cycle($sformatf("A%0d", n), 1'b1, 1'b0, 1'b0, '0, mk(2'd1, wv[1], wv[0], 1'b0, 1'b0));
    end

    // B: drop RUN while high -> drain; then drop RUN while low -> immediate halt
    async_reset("B_rst");
    for (int n = 0; n < 11; n++) begin
      logic [5:0] e;
      wv = wave(n, DEF);
      if (n < 5)       e = mk(2'd1, wv[1], wv[0], 1'b0, 1'b0);
      else if (n < 8)  e = mk(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      else             e = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle($sformatf("B%0d", n), n < 5, 1'b0, 1'b0, '0, e);
    end
    for (int r = 0; r < 6; r++) begin
      drive_cycle($sformatf("B2_%0d", r), r < 3, 1'b0, 1'b0, '0,
                  mk((r < 3) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // C: single step, second STEP during the step is ignored
    async_reset("C_rst");
    for (int n = 0; n < 12; n++) begin
      logic [5:0] e;
      wv = wave(n, DEF);
      if (n < 8)       e = mk(2'd2, wv[1], wv[0], 1'b0, 1'b0);
      else if (n == 8) e = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      else             e = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle($sformatf("C%0d", n), 1'b0, (n == 0) || (n == 2), 1'b0, '0, e);
    end

    // D: ratio update while running, applied at the falling boundary
    async_reset("D_rst");
    for (int n = 0; n < 18; n++) begin
      wv = (n < 8) ? wave(n, DEF) : wave(n - 8, 1);
      drive_cycle($sformatf("D%0d", n), 1'b1, 1'b0, n == 5, (n == 5) ? W'(1) : W'(0),
                  mk(2'd1, wv[1], wv[0], n == 9, 1'b0));
    end

    // E: clamp + overwrite gives one ack and div=5; a lone zero write clamps to 1
    async_reset("E_rst");
    for (int n = 0; n < 42; n++) begin
      if (n < 8)       wv = wave(n, DEF);
      else if (n < 32) wv = wave(n - 8, 5);
      else             wv = wave(n - 32, 1);
      drive_cycle($sformatf("E%0d", n), 1'b1, 1'b0, (n == 1) || (n == 2) || (n == 22),
                  (n == 2) ? W'(5) : W'(0), mk(2'd1, wv[1], wv[0], (n == 9) || (n == 33), 1'b0));
    end

    // F: write in HALT, run, async reset while high, default ratio restored
    async_reset("F_rst");
    drive_cycle("F_h0", 1'b0, 1'b0, 1'b1, W'(1), mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_cycle("F_h1", 1'b0, 1'b0, 1'b0, '0, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_cycle("F_h2", 1'b0, 1'b0, 1'b0, '0, mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int n = 0; n < 3; n++) begin
      wv = wave(n, 1);
      drive_cycle($sformatf("F_r%0d", n), 1'b1, 1'b0, 1'b0, '0, mk(2'd1, wv[1], wv[0], 1'b0, 1'b0));
    end
    async_reset("F_rst_mid");
    for (int n = 0; n < 9; n++) begin
      wv = wave(n, DEF);
      drive_cycle($sformatf("F_d%0d", n), 1'b1, 1'b0, 1'b0, '0, mk(2'd1, wv[1], wv[0], 1'b0, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
